// File: rtl/mem_vector_access.sv
// Memory-stage data-memory access unit.
// Splits each 256-bit vector load or store into eight 32-bit beats on a single-ported
// synchronous memory. Holds the pipeline through StallM while an access is in flight.
module mem_vector_access #(
  parameter int N = 32,
  parameter int V = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         MemReadM,
  input  logic         MemWriteM,
  input  logic         MemReadVM,
  input  logic         MemWriteVM,
  input  logic [N-1:0] ALUResultM,
  input  logic [N-1:0] WriteDataM,
  input  logic [V-1:0] WriteDataVM,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] mem_addr,
  output logic         mem_we,
  output logic         mem_re,
  output logic [N-1:0] mem_wdata,
  output logic [N-1:0] ReadDataM,
  output logic [V-1:0] ReadDataVM,
  output logic         StallM
);

  localparam int unsigned BEATS = V / N;

  typedef enum logic [2:0] {IDLE, SRD, VRD, VRDL, VWR, DONE} state_t;

  state_t         state_q, state_d;
  logic [2:0]     beat_q, beat_d;
  logic [N-1:0]   base_q, base_d;
  logic [N-1:0]   rdata_q, rdata_d;
  logic [V-1:0]   vdata_q, vdata_d;

  logic           we, re, stall;
  logic [N-1:0]   addr, wdata;
  logic [N-1:0]   aligned_addr;
  logic [N-1:0]   beat_addr;
  logic [N-1:0]   beat_wlane;
  logic [N-1:0]   lane0;

  assign aligned_addr = {ALUResultM[N-1:2], 2'b00};
  // Adding base and offset wraps modulo 2^N, so a burst can cross 0xFFFFFFFC into 0.
  assign beat_addr    = base_q + {{(N-5){1'b0}}, beat_q, 2'b00};
  assign lane0        = WriteDataVM[N-1:0];

  // Pick the store lane for the current beat. WriteDataVM stays stable while StallM is high.
  always_comb begin
    beat_wlane = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (beat_q == 3'(i)) beat_wlane = WriteDataVM[i*N +: N];
    end
  end

  // Next-state logic, memory-port drive and load-data capture.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    rdata_d = rdata_q;
    vdata_d = vdata_q;
    we      = 1'b0;
    re      = 1'b0;
    stall   = 1'b0;
    addr    = '0;
    wdata   = '0;
    unique case (state_q)
      IDLE: begin
        beat_d = '0;
        if (MemWriteVM) begin
          stall   = 1'b1;
          we      = 1'b1;
          addr    = aligned_addr;
          wdata   = lane0;
          base_d  = aligned_addr;
          beat_d  = 3'd1;
          state_d = VWR;
        end else if (MemReadVM) begin
          stall   = 1'b1;
          re      = 1'b1;
          addr    = aligned_addr;
          base_d  = aligned_addr;
          beat_d  = 3'd1;
          state_d = VRD;
        end else if (MemWriteM) begin
          we      = 1'b1;
          addr    = aligned_addr;
          wdata   = WriteDataM;
        end else if (MemReadM) begin
          stall   = 1'b1;
          re      = 1'b1;
          addr    = aligned_addr;
          state_d = SRD;
        end
      end
      SRD: begin
        stall   = 1'b1;
        rdata_d = mem_rdata;
        state_d = DONE;
      end
      VRD: begin
        // The read issued last cycle returns now, so it belongs in lane beat_q-1.
        stall = 1'b1;
        re    = 1'b1;
        addr  = beat_addr;
        for (int unsigned i = 0; i < BEATS; i++) begin
          if (beat_q - 3'd1 == 3'(i)) vdata_d[i*N +: N] = mem_rdata;
        end
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd7) state_d = VRDL;
      end
      VRDL: begin
        stall                       = 1'b1;
        vdata_d[(BEATS-1)*N +: N]   = mem_rdata;
        state_d                     = DONE;
      end
      VWR: begin
        stall  = 1'b1;
        we     = 1'b1;
        addr   = beat_addr;
        wdata  = beat_wlane;
        beat_d = beat_q + 3'd1;
        if (beat_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        beat_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port and stall outputs are forced low for as long as reset is held, even if requests are present.
  always_comb begin
    mem_we    = we & rst;
    mem_re    = re & rst;
    StallM    = stall & rst;
    mem_addr  = rst ? addr  : '0;
    mem_wdata = rst ? wdata : '0;
  end

  // State, beat counter, base address and load-result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      rdata_q <= '0;
      vdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      rdata_q <= rdata_d;
      vdata_q <= vdata_d;
    end
  end

  assign ReadDataM  = rdata_q;
  assign ReadDataVM = vdata_q;

endmodule

// File: tb/tb_mem_vector_access.sv
// Self-checking bench for mem_vector_access: a synchronous memory model plus a word-level reference memory.
module tb_mem_vector_access;

  logic         clk;
  logic         rst;
  logic         MemReadM, MemWriteM, MemReadVM, MemWriteVM;
  logic [31:0]  ALUResultM, WriteDataM;
  logic [255:0] WriteDataVM;
  logic [31:0]  mem_rdata;
  logic [31:0]  mem_addr;
  logic         mem_we, mem_re;
  logic [31:0]  mem_wdata;
  logic [31:0]  ReadDataM;
  logic [255:0] ReadDataVM;
  logic         StallM;

  mem_vector_access #(.N(32), .V(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .MemReadVM  (MemReadVM),
    .MemWriteVM (MemWriteVM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .WriteDataVM(WriteDataVM),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_wdata  (mem_wdata),
    .ReadDataM  (ReadDataM),
    .ReadDataVM (ReadDataVM),
    .StallM     (StallM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the DUT's port, plus a log of every access it sees.
  logic [31:0] dut_mem [logic [31:0]];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      dut_mem[mem_addr] = mem_wdata;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (mem_re === 1'b1) begin
      mem_rdata <= dut_mem.exists(mem_addr) ? dut_mem[mem_addr] : 32'h0;
      rd_addr_q.push_back(mem_addr);
    end
  end

  // Reference: word memory updated by whole transactions.
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] last_sld;
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // req = {MemWriteVM, MemReadVM, MemWriteM, MemReadM}
  task automatic run_op(input string tag, input logic [3:0] req, input logic [31:0] a,
                        input logic [31:0] sd, input logic [255:0] vd);
    int           stalls;
    int           cyc;
    int           kind;
    int           exp_stall, exp_w, exp_r;
    logic [31:0]  base;
    logic [31:0]  exp_addr[8];
    logic [255:0] exp_v;
    logic [31:0]  exp_s;
    logic [31:0]  lane;
    stalls = 0;
    cyc    = 0;
    base   = a & 32'hFFFF_FFFC;
    kind   = req[3] ? 3 : req[2] ? 2 : req[1] ? 1 : 0;
    for (int i = 0; i < 8; i++) exp_addr[i] = base + 32'(4 * i);
    exp_v = '0;
    for (int i = 0; i < 8; i++) exp_v[i*32 +: 32] = ref_rd(exp_addr[i]);
    exp_s = ref_rd(base);
    case (kind)
      3:       begin exp_stall = 8; exp_w = 8; exp_r = 0; end
      2:       begin exp_stall = 9; exp_w = 0; exp_r = 8; end
      1:       begin exp_stall = 0; exp_w = 1; exp_r = 0; end
      default: begin exp_stall = 2; exp_w = 0; exp_r = 1; end
    endcase
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();

    @(negedge clk);
    {MemWriteVM, MemReadVM, MemWriteM, MemReadM} = req;
    ALUResultM  = a;
    WriteDataM  = sd;
    WriteDataVM = vd;
    #1;
    while (StallM === 1'b1 && cyc < 40) begin
      stalls++;
      @(negedge clk); #1;
      cyc++;
    end
    // Now in DONE (or the single scalar-store cycle): results must be valid here.
    chk({tag, " stall_cycles"}, 256'(stalls), 256'(exp_stall));
    if (kind == 2) begin
      chk({tag, " ReadDataVM"}, ReadDataVM, exp_v);
      chk({tag, " ReadDataM_hold"}, 256'(ReadDataM), 256'(last_sld));
    end
    if (kind == 0) begin
      chk({tag, " ReadDataM"}, 256'(ReadDataM), 256'(exp_s));
      last_sld = exp_s;
    end
    @(negedge clk);
    {MemWriteVM, MemReadVM, MemWriteM, MemReadM} = 4'b0000;
    @(negedge clk);

    chk({tag, " write_count"}, 256'(wr_addr_q.size()), 256'(exp_w));
    chk({tag, " read_count"},  256'(rd_addr_q.size()), 256'(exp_r));
    for (int i = 0; i < wr_addr_q.size() && i < exp_w; i++) begin
      lane = (kind == 3) ? vd[i*32 +: 32] : sd;
      chk($sformatf("%s waddr%0d", tag, i), 256'(wr_addr_q[i]), 256'(exp_addr[i]));
      chk($sformatf("%s wdata%0d", tag, i), 256'(wr_data_q[i]), 256'(lane));
    end
    for (int i = 0; i < rd_addr_q.size() && i < exp_r; i++)
      chk($sformatf("%s raddr%0d", tag, i), 256'(rd_addr_q[i]), 256'(exp_addr[i]));

    if (kind == 3) for (int i = 0; i < 8; i++) ref_mem[exp_addr[i]] = vd[i*32 +: 32];
    if (kind == 1) ref_mem[base] = sd;
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] pat;
    logic [3:0]   req;
    logic [31:0]  ra;
    rst = 1'b0;
    {MemWriteVM, MemReadVM, MemWriteM, MemReadM} = 4'b0100;
    ALUResultM = 32'h100; WriteDataM = '0; WriteDataVM = '0;
    mem_rdata = '0;
    last_sld = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst StallM",     256'(StallM),    256'(0));
    chk("rst mem_re",     256'(mem_re),    256'(0));
    chk("rst mem_we",     256'(mem_we),    256'(0));
    chk("rst mem_addr",   256'(mem_addr),  256'(0));
    chk("rst mem_wdata",  256'(mem_wdata), 256'(0));
    chk("rst ReadDataM",  256'(ReadDataM), 256'(0));
    chk("rst ReadDataVM", ReadDataVM,      256'(0));
    {MemWriteVM, MemReadVM, MemWriteM, MemReadM} = 4'b0000;
    @(negedge clk);
    rst = 1'b1;

    run_op("sst", 4'b0010, 32'h40, 32'hDEADBEEF, '0);
    run_op("sld", 4'b0001, 32'h43, '0, '0);

    for (int i = 0; i < 8; i++) pat[i*32 +: 32] = 32'h11111111 * 32'(i + 1);
    run_op("vst", 4'b1000, 32'h100, '0, pat);
    run_op("vld", 4'b0100, 32'h100, '0, '0);

    run_op("wrap_vst", 4'b1000, 32'hFFFFFFF0, '0, rand_vec());
    run_op("wrap_vld", 4'b0100, 32'hFFFFFFF2, '0, '0);

    run_op("prio", 4'b0111, 32'h100, 32'hCAFEF00D, '0);

    // Reset during beat 4 of a vector load.
    @(negedge clk);
    {MemWriteVM, MemReadVM, MemWriteM, MemReadM} = 4'b0100;
    ALUResultM = 32'h100;
    repeat (4) @(negedge clk);
    #1;
    chk("midrst beat4 addr", 256'(mem_addr), 256'(32'h110));
    rst = 1'b0;
    #1;
    chk("midrst StallM",     256'(StallM),   256'(0));
    chk("midrst mem_re",     256'(mem_re),   256'(0));
    chk("midrst mem_addr",   256'(mem_addr), 256'(0));
    chk("midrst ReadDataVM", ReadDataVM,     256'(0));
    @(negedge clk);
    {MemWriteVM, MemReadVM, MemWriteM, MemReadM} = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    last_sld = '0;
    run_op("post_rst_sld", 4'b0001, 32'h41, '0, '0);

    for (int n = 0; n < 24; n++) begin
      req = 4'($urandom_range(1, 15));
      ra  = 32'h200 + 32'($urandom_range(0, 255));
      run_op($sformatf("rnd%0d", n), req, ra, $urandom, rand_vec());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
